pll_mdrp_ctrl: RTL and testbench
================================

PLL_MDRP_CTRL -- requirements
Module: pll_mdrp_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, cycles from read opcode to valid mdrdo (legal 1..7).
REQ-002 SHALL have parameter RST_CYCLES, default 16, pll_rst pulse width in mdclk cycles (legal 1..255).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, max mdclk cycles waiting for pll_lock (legal 1..65535).
REQ-004 SHALL have parameter RELOCK, default 1; 1 = reset PLL and await lock after every write, 0 = skip.
REQ-005 SHALL have ports: mdclk in 1 (the only clock), reset in 1 (synchronous, active-high).
REQ-006 SHALL have ports: cfg_req in 1 (request strobe), cfg_wr in 1 (1 = write, 0 = read), cfg_addr in 8 (MDRP register address), cfg_wdata in 8 (write data).
REQ-007 SHALL have ports: cfg_rdata out 8 (read data), cfg_busy out 1, cfg_done out 1 (one-cycle completion pulse), cfg_err out 1 (lock timeout, sticky until next accepted request).
REQ-008 SHALL have ports: mdopc out 2, mdainc out 1, mdwdi out 8, mdrdo in 8 (PLL dynamic-reconfiguration port).
REQ-009 SHALL have ports: pll_lock in 1, pll_rst out 1.

Function
REQ-010 SHALL encode mdopc as 00 = NOP, 01 = write, 10 = read, 11 = address load (address on mdwdi).
REQ-011 SHALL hold mdainc at 0 in all states (single-register accesses only).
REQ-012 SHALL implement states IDLE, ADDR, WRITE, READ, RD_WAIT, PLLRST, LOCK_WAIT, DONE.
REQ-013 SHALL accept cfg_req only in IDLE; cfg_req while cfg_busy=1 SHALL be ignored, not queued.
REQ-014 SHALL register cfg_wr, cfg_addr, cfg_wdata on acceptance; later input changes SHALL not affect the transaction.
REQ-015 SHALL drive cfg_busy=1 from the cycle after acceptance through DONE inclusive.
REQ-016 IDLE -> ADDR on accept; ADDR drives mdopc=11, mdwdi=addr for exactly one cycle.
REQ-017 ADDR -> WRITE if write, else READ; WRITE drives mdopc=01, mdwdi=wdata for one cycle; READ drives mdopc=10 for one cycle.
REQ-018 READ -> RD_WAIT; RD_WAIT counts RD_LAT cycles after the READ cycle, then captures mdrdo into cfg_rdata and -> DONE.
REQ-019 WRITE -> PLLRST if RELOCK=1, else DONE.
REQ-020 PLLRST SHALL hold pll_rst=1 for exactly RST_CYCLES cycles, then -> LOCK_WAIT.
REQ-021 LOCK_WAIT -> DONE on first cycle pll_lock=1; if LOCK_TIMEOUT cycles elapse without lock, set cfg_err=1 and -> DONE.
REQ-022 pll_lock sampled only in LOCK_WAIT; lock asserted on the same cycle as timeout expiry SHALL count as success (cfg_err=0).
REQ-023 DONE SHALL last one cycle with cfg_done=1, then -> IDLE.
REQ-024 Outside ADDR/WRITE/READ, mdopc SHALL be 00 and mdwdi SHALL be 00.
REQ-025 cfg_rdata SHALL hold its last captured value until the next read completes; writes SHALL not alter it.
REQ-026 cfg_err SHALL clear on the cycle a new request is accepted.
REQ-027 Read latency req-accept to cfg_done: 3 + RD_LAT cycles; write with RELOCK=0: 3 cycles.
REQ-028 Counters SHALL be wide enough for parameter maxima and SHALL not wrap within a state.

Reset
REQ-029 Reset SHALL force state IDLE, mdopc=00, mdainc=0, mdwdi=00, pll_rst=0, cfg_busy=0, cfg_done=0, cfg_err=0, cfg_rdata=00, all counters 0.
REQ-030 Reset asserted mid-transaction SHALL abort it on the next edge with no cfg_done pulse; an in-progress pll_rst pulse SHALL end immediately.
REQ-031 cfg_req coincident with reset SHALL be ignored.

Verification
REQ-032 Read: cfg_addr=0x12, RD_LAT=2, mdrdo=0xA5 -> mdopc 11/0x12, then 10, cfg_rdata=0xA5, cfg_done 5 cycles after accept.
REQ-033 Write RELOCK=1: addr 0x08, wdata 0x3C, pll_lock rises 10 cycles into LOCK_WAIT -> mdopc 11/0x08, 01/0x3C, pll_rst high 16 cycles, cfg_done, cfg_err=0.
REQ-034 Timeout: LOCK_TIMEOUT=100, pll_lock held 0 -> cfg_done after exactly 100 LOCK_WAIT cycles, cfg_err=1; next accepted request clears it.
REQ-035 Busy drop: second cfg_req during RD_WAIT -> ignored, exactly one cfg_done, cfg_rdata from first address only.
REQ-036 Reset in PLLRST cycle 5 -> next cycle pll_rst=0, IDLE, no cfg_done, all outputs at reset values.
REQ-037 Lock coincident with timeout expiry -> cfg_done with cfg_err=0.

Source files
------------

// File: rtl/pll_mdrp_ctrl.sv
// Sequences single-register MDRP reads/writes with an optional PLL reset/relock after writes.
// Latency: read 3+RD_LAT, write 3 (+reset/lock time); requests arriving while busy are dropped, not queued.
module pll_mdrp_ctrl #(
  parameter int RD_LAT       = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RELOCK       = 1
) (
  input  logic       mdclk,
  input  logic       reset,
  input  logic       cfg_req,
  input  logic       cfg_wr,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  output logic [7:0] cfg_rdata,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  input  logic       pll_lock,
  output logic       pll_rst
);

  localparam logic [15:0] RD_LAST   = 16'(RD_LAT - 1);
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WRITE, S_READ, S_RD_WAIT, S_PLLRST, S_LOCK_WAIT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic        wr_q;
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        err_q;
  logic        accept;
  logic        capture;
  logic        set_err;

  always_ff @(posedge mdclk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      // Only the waiting states count, and the count restarts on every state change.
      if (state_nxt == state &&
          (state == S_RD_WAIT || state == S_PLLRST || state == S_LOCK_WAIT))
        cnt <= cnt + 16'd1;
      else
        cnt <= '0;
      if (accept) begin
        wr_q    <= cfg_wr;
        addr_q  <= cfg_addr;
        wdata_q <= cfg_wdata;
        err_q   <= 1'b0;
      end
      if (set_err) err_q <= 1'b1;
      if (capture) rdata_q <= mdrdo;
    end
  end

  always_comb begin
    state_nxt = state;
    mdopc     = 2'b00;
    mdwdi     = 8'h00;
    pll_rst   = 1'b0;
    cfg_done  = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_req) begin
          accept    = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        mdopc     = 2'b11;
        mdwdi     = addr_q;
        state_nxt = wr_q ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        mdopc     = 2'b01;
        mdwdi     = wdata_q;
        state_nxt = (RELOCK != 0) ? S_PLLRST : S_DONE;
      end
      S_READ: begin
        mdopc     = 2'b10;
        state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (cnt == RD_LAST) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_PLLRST: begin
        pll_rst = 1'b1;
        if (cnt == RST_LAST) state_nxt = S_LOCK_WAIT;
      end
      S_LOCK_WAIT: begin
        // Lock seen on the final allowed cycle still wins over the timeout.
        if (pll_lock) begin
          state_nxt = S_DONE;
        end else if (cnt == LOCK_LAST) begin
          set_err   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        cfg_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cfg_busy  = (state != S_IDLE);
  assign cfg_rdata = rdata_q;
  assign cfg_err   = err_q;
  assign mdainc    = 1'b0;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Scoreboard bench for pll_mdrp_ctrl: stimulus pushes expected MDRP ops, reset pulses and completions;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_pll_mdrp_ctrl;
  localparam int RD_LAT  = 2;
  localparam int RST_CYC = 16;
  localparam int LOCK_TO = 100;

  logic       mdclk = 1'b0;
  logic       reset;
  logic       cfg_req;
  logic       cfg_wr;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       cfg_busy;
  logic       cfg_done;
  logic       cfg_err;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       pll_lock;
  logic       pll_rst;

  pll_mdrp_ctrl #(
    .RD_LAT(RD_LAT), .RST_CYCLES(RST_CYC), .LOCK_TIMEOUT(LOCK_TO), .RELOCK(1)
  ) dut (
    .mdclk(mdclk), .reset(reset),
    .cfg_req(cfg_req), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .mdopc(mdopc), .mdainc(mdainc), .mdwdi(mdwdi), .mdrdo(mdrdo),
    .pll_lock(pll_lock), .pll_rst(pll_rst)
  );

  always #5 mdclk = ~mdclk;

  int cyc = 0;
  always @(posedge mdclk) cyc <= cyc + 1;

  // PLL register model: data appears on mdrdo only exactly RD_LAT cycles after the read opcode.
  logic [7:0] regs [256];
  logic [7:0] cur_addr = 8'h00;
  int         rd_at = -100;
  always @(posedge mdclk) begin
    if (mdopc == 2'b11) cur_addr <= mdwdi;
    if (mdopc == 2'b01) regs[cur_addr] <= mdwdi;
    if (mdopc == 2'b10) rd_at <= cyc + RD_LAT;
  end
  assign mdrdo = (cyc == rd_at) ? regs[cur_addr] : 8'hEE;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t       done_q[$];
  logic [9:0] op_q[$];
  int         rst_q[$];
  int         vec  = 0;
  int         miss = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  int   rst_run = 0;
  exp_t e;
  always @(negedge mdclk) begin
    chk("mdainc", int'(mdainc), 0);
    if (mdopc != 2'b00 || mdwdi != 8'h00) begin
      if (op_q.size() == 0) chk("unexpected_op", int'({mdopc, mdwdi}), 0);
      else chk("mdrp_op", int'({mdopc, mdwdi}), int'(op_q.pop_front()));
    end
    if (pll_rst) begin
      rst_run++;
    end else if (rst_run > 0) begin
      if (rst_q.size() == 0) chk("unexpected_rst", rst_run, 0);
      else chk("rst_width", rst_run, rst_q.pop_front());
      rst_run = 0;
    end
    if (cfg_done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_rdata", int'(cfg_rdata), int'(e.rdata));
        chk("done_err", int'(cfg_err), int'(e.err));
      end
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge mdclk);
      #1;
    end
  endtask

  // Present one request for one cycle, then scramble the inputs so late changes would be visible.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] d);
    cfg_req   = 1'b1;
    cfg_wr    = wr;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge mdclk);
    #1;
    cfg_req   = 1'b0;
    cfg_wr    = ~wr;
    cfg_addr  = 8'hFF;
    cfg_wdata = 8'hFF;
    chk("busy_after_accept", int'(cfg_busy), 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] expd);
    int acc;
    acc = cyc;
    op_q.push_back({2'b11, a});
    op_q.push_back({2'b10, 8'h00});
    done_q.push_back('{rdata: expd, err: 1'b0, cyc: acc + 3 + RD_LAT});
    issue(1'b0, a, 8'h00);
    wait_to(acc + 3 + RD_LAT + 2);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, int'(cfg_busy), 0);
    chk({tag, "_done"}, int'(cfg_done), 0);
    chk({tag, "_err"}, int'(cfg_err), 0);
    chk({tag, "_rdata"}, int'(cfg_rdata), 0);
    chk({tag, "_mdopc"}, int'(mdopc), 0);
    chk({tag, "_mdwdi"}, int'(mdwdi), 0);
    chk({tag, "_pll_rst"}, int'(pll_rst), 0);
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 256; i++) regs[i] = 8'h00;
    regs[8'h12] = 8'hA5;
    regs[8'h34] = 8'h5A;

    // Reset with a coincident request that must be ignored
    reset     = 1'b1;
    cfg_req   = 1'b1;
    cfg_wr    = 1'b1;
    cfg_addr  = 8'h55;
    cfg_wdata = 8'h66;
    pll_lock  = 1'b0;
    repeat (3) @(posedge mdclk);
    #1;
    check_reset_outputs("reset");
    reset   = 1'b0;
    cfg_req = 1'b0;
    @(posedge mdclk);
    #1;
    chk("idle_after_reset_busy", int'(cfg_busy), 0);

    // Read 0x12 -> 0xA5, done 5 cycles after accept
    do_read(8'h12, 8'hA5);

    // Write 0x08/0x3C with relock; lock arrives 10 cycles into LOCK_WAIT
    acc = cyc;
    op_q.push_back({2'b11, 8'h08});
    op_q.push_back({2'b01, 8'h3C});
    rst_q.push_back(RST_CYC);
    done_q.push_back('{rdata: 8'hA5, err: 1'b0, cyc: acc + 3 + RST_CYC + 11});
    issue(1'b1, 8'h08, 8'h3C);
    wait_to(acc + 3 + RST_CYC + 10);
    pll_lock = 1'b1;
    wait_to(acc + 3 + RST_CYC + 12);
    pll_lock = 1'b0;
    wait_to(acc + 3 + RST_CYC + 14);

    do_read(8'h08, 8'h3C);

    // Second request during RD_WAIT is dropped
    acc = cyc;
    op_q.push_back({2'b11, 8'h34});
    op_q.push_back({2'b10, 8'h00});
    done_q.push_back('{rdata: 8'h5A, err: 1'b0, cyc: acc + 5});
    issue(1'b0, 8'h34, 8'h00);
    wait_to(acc + 3);
    cfg_req  = 1'b1;
    cfg_wr   = 1'b0;
    cfg_addr = 8'h12;
    @(posedge mdclk);
    #1;
    cfg_req = 1'b0;
    chk("busy_during_drop", int'(cfg_busy), 1);
    wait_to(acc + 9);

    // Lock timeout: exactly LOCK_TO cycles of LOCK_WAIT, err set and sticky
    acc = cyc;
    op_q.push_back({2'b11, 8'h20});
    op_q.push_back({2'b01, 8'h77});
    rst_q.push_back(RST_CYC);
    done_q.push_back('{rdata: 8'h5A, err: 1'b1, cyc: acc + 3 + RST_CYC + LOCK_TO});
    issue(1'b1, 8'h20, 8'h77);
    wait_to(acc + 3 + RST_CYC + LOCK_TO + 3);
    chk("err_sticky_idle", int'(cfg_err), 1);

    // Next accepted request clears err in its first busy cycle
    acc = cyc;
    op_q.push_back({2'b11, 8'h20});
    op_q.push_back({2'b10, 8'h00});
    done_q.push_back('{rdata: 8'h77, err: 1'b0, cyc: acc + 5});
    issue(1'b0, 8'h20, 8'h00);
    chk("err_clear_on_accept", int'(cfg_err), 0);
    wait_to(acc + 7);

    // Lock on the very last LOCK_WAIT cycle counts as success
    acc = cyc;
    op_q.push_back({2'b11, 8'h21});
    op_q.push_back({2'b01, 8'h11});
    rst_q.push_back(RST_CYC);
    done_q.push_back('{rdata: 8'h77, err: 1'b0, cyc: acc + 3 + RST_CYC + LOCK_TO});
    issue(1'b1, 8'h21, 8'h11);
    wait_to(acc + 3 + RST_CYC + LOCK_TO - 1);
    pll_lock = 1'b1;
    wait_to(acc + 3 + RST_CYC + LOCK_TO + 1);
    pll_lock = 1'b0;
    wait_to(acc + 3 + RST_CYC + LOCK_TO + 3);

    // Reset during PLLRST cycle 5 aborts: pulse cut to 5, no done, outputs at reset values
    acc = cyc;
    op_q.push_back({2'b11, 8'h22});
    op_q.push_back({2'b01, 8'h44});
    rst_q.push_back(5);
    issue(1'b1, 8'h22, 8'h44);
    wait_to(acc + 7);
    chk("pll_rst_before_abort", int'(pll_rst), 1);
    reset = 1'b1;
    @(posedge mdclk);
    #1;
    check_reset_outputs("abort");
    reset = 1'b0;
    wait_to(acc + 30);

    do_read(8'h08, 8'h3C);

    wait_to(cyc + 5);
    while (done_q.size() > 0) begin
      void'(done_q.pop_front());
      chk("missing_done", 0, 1);
    end
    while (op_q.size() > 0) begin
      void'(op_q.pop_front());
      chk("missing_op", 0, 1);
    end
    while (rst_q.size() > 0) begin
      void'(rst_q.pop_front());
      chk("missing_rst", 0, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
